// File: rtl/avalon_camera_regfile.sv
// ============================================================================
//  Module   : avalon_camera_regfile
//  Brief    : Avalon-MM camera config regfile, shadow/active banks, frame-synced commit
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module avalon_camera_regfile #(
    parameter int                         NUM_REGS = 15,
    parameter int                         DATA_W   = 16,
    parameter logic [NUM_REGS*DATA_W-1:0] DEFAULTS = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [4:0]                   avs_s1_address,
    input  logic                         avs_s1_read,
    input  logic                         avs_s1_write,
    input  logic [31:0]                  avs_s1_writedata,
    input  logic [3:0]                   avs_s1_byteenable,
    output logic [31:0]                  avs_s1_readdata,
    output logic                         avs_s1_readdatavalid,
    input  logic                         frame_start,
    output logic [NUM_REGS*DATA_W-1:0]   avs_export_regs,
    output logic                         avs_export_update_req,
    input  logic                         avs_export_update_ack,
    output logic                         avs_export_cam_soft_reset_n
);

    localparam logic [4:0] c_ADDR_STATUS = 5'h1D;
    localparam logic [4:0] c_ADDR_CTRL   = 5'h1E;
    localparam logic [4:0] c_ADDR_SOFT   = 5'h1F;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_PENDING = 2'd1;
    localparam logic [1:0] c_REQ     = 2'd2;

    logic [DATA_W-1:0] r_shadow [NUM_REGS];
    logic [DATA_W-1:0] r_active [NUM_REGS];
    logic [1:0]        r_state;
    logic [7:0]        r_commit_cnt;
    logic              r_overrun;
    logic              r_soft_reset_n;
    logic [31:0]       r_readdata;
    logic              r_readdatavalid;

    logic              w_wr;
    logic              w_commit;
    logic              w_copy;
    logic              w_overrun_set;
    logic              w_overrun_clr;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] w_wmask;
    logic [31:0]       w_rdmux;
    logic              w_unused;

    // Reads win over a simultaneous write, so the write is suppressed here.
    assign w_wr          = avs_s1_write & ~avs_s1_read;
    assign w_commit      = w_wr && (avs_s1_address == c_ADDR_CTRL) && avs_s1_writedata[0];
    assign w_overrun_clr = w_wr && (avs_s1_address == c_ADDR_STATUS) && avs_s1_writedata[2];
    assign w_unused      = ^{avs_s1_writedata, avs_s1_byteenable};

    always_comb begin
        w_wmask = '0;
        for (int b = 0; b < DATA_W; b++) begin
            w_wmask[b] = avs_s1_byteenable[b / 8];
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_copy        = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_commit) begin
                    if (avs_s1_writedata[1]) begin
                        w_copy      = 1'b1;
                        w_state_nxt = c_REQ;
                    end else begin
                        w_state_nxt = c_PENDING;
                    end
                end
            end
            c_PENDING: begin
                w_overrun_set = w_commit;
                if (frame_start) begin
                    w_copy      = 1'b1;
                    w_state_nxt = c_REQ;
                end
            end
            c_REQ: begin
                w_overrun_set = w_commit;
                if (avs_export_update_ack) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_rdmux = '0;
        case (avs_s1_address)
            c_ADDR_STATUS: w_rdmux = {16'b0, r_commit_cnt, 5'b0, r_overrun, r_state};
            c_ADDR_SOFT:   w_rdmux = {31'b0, r_soft_reset_n};
            default: begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (avs_s1_address == 5'(i)) begin
                        w_rdmux = 32'(r_shadow[i]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= DEFAULTS[i*DATA_W +: DATA_W];
                r_active[i] <= DEFAULTS[i*DATA_W +: DATA_W];
            end
            r_state         <= c_IDLE;
            r_commit_cnt    <= 8'd0;
            r_overrun       <= 1'b0;
            r_soft_reset_n  <= 1'b1;
            r_readdata      <= 32'd0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_readdatavalid <= avs_s1_read;
            if (avs_s1_read) begin
                r_readdata <= w_rdmux;
            end
            // Copy sees the pre-write shadow because both use non-blocking updates.
            if (w_copy) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
                r_commit_cnt <= r_commit_cnt + 8'd1;
            end
            if (w_wr) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (avs_s1_address == 5'(i)) begin
                        r_shadow[i] <= (r_shadow[i] & ~w_wmask) |
                                       (avs_s1_writedata[DATA_W-1:0] & w_wmask);
                    end
                end
            end
            if (w_wr && (avs_s1_address == c_ADDR_SOFT) && avs_s1_byteenable[0]) begin
                r_soft_reset_n <= avs_s1_writedata[0];
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
            assign avs_export_regs[g*DATA_W +: DATA_W] = r_active[g];
        end
    endgenerate

    assign avs_s1_readdata             = r_readdata;
    assign avs_s1_readdatavalid        = r_readdatavalid;
    assign avs_export_update_req       = (r_state == c_REQ);
    assign avs_export_cam_soft_reset_n = r_soft_reset_n;

endmodule

`default_nettype wire

// File: tb/tb_avalon_camera_regfile.sv
// ============================================================================
//  Module   : tb_avalon_camera_regfile
//  Brief    : Directed self-checking bench for avalon_camera_regfile
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_avalon_camera_regfile;

    localparam int c_NUM_REGS = 15;
    localparam int c_DATA_W   = 16;
    localparam logic [c_NUM_REGS*c_DATA_W-1:0] c_DEFS =
        ({{(c_NUM_REGS*c_DATA_W-16){1'b0}}, 16'h07C0} << 48) |
         {{(c_NUM_REGS*c_DATA_W-16){1'b0}}, 16'h0140};

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  avs_s1_address;
    logic        avs_s1_read;
    logic        avs_s1_write;
    logic [31:0] avs_s1_writedata;
    logic [3:0]  avs_s1_byteenable;
    logic [31:0] avs_s1_readdata;
    logic        avs_s1_readdatavalid;
    logic        frame_start;
    logic [c_NUM_REGS*c_DATA_W-1:0] avs_export_regs;
    logic        avs_export_update_req;
    logic        avs_export_update_ack;
    logic        avs_export_cam_soft_reset_n;

    int n_cmp = 0;
    int n_err = 0;

    avalon_camera_regfile #(
        .NUM_REGS (c_NUM_REGS),
        .DATA_W   (c_DATA_W),
        .DEFAULTS (c_DEFS)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .avs_s1_address              (avs_s1_address),
        .avs_s1_read                 (avs_s1_read),
        .avs_s1_write                (avs_s1_write),
        .avs_s1_writedata            (avs_s1_writedata),
        .avs_s1_byteenable           (avs_s1_byteenable),
        .avs_s1_readdata             (avs_s1_readdata),
        .avs_s1_readdatavalid        (avs_s1_readdatavalid),
        .frame_start                 (frame_start),
        .avs_export_regs             (avs_export_regs),
        .avs_export_update_req       (avs_export_update_req),
        .avs_export_update_ack       (avs_export_update_ack),
        .avs_export_cam_soft_reset_n (avs_export_cam_soft_reset_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic avs_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_s1_address    = a;
        avs_s1_writedata  = d;
        avs_s1_byteenable = be;
        avs_s1_write      = 1'b1;
        tick();
        avs_s1_write      = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        avs_s1_address = a;
        avs_s1_read    = 1'b1;
        tick();
        avs_s1_read    = 1'b0;
        check({tag, "_valid"}, {31'b0, avs_s1_readdatavalid}, 32'd1);
        check(tag, avs_s1_readdata, exp);
    endtask

    function automatic logic [31:0] exp_reg(input int i);
        return {16'b0, avs_export_regs[i*c_DATA_W +: c_DATA_W]};
    endfunction

    initial begin
        reset                 = 1'b1;
        avs_s1_address        = '0;
        avs_s1_read           = 1'b0;
        avs_s1_write          = 1'b0;
        avs_s1_writedata      = '0;
        avs_s1_byteenable     = '0;
        frame_start           = 1'b0;
        avs_export_update_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_req",   {31'b0, avs_export_update_req}, 32'd0);
        check("rst_softn", {31'b0, avs_export_cam_soft_reset_n}, 32'd1);
        check("rst_rdv",   {31'b0, avs_s1_readdatavalid}, 32'd0);
        check("rst_rdata", avs_s1_readdata, 32'd0);
        check("rst_act0",  exp_reg(0), 32'h0140);
        check("rst_act3",  exp_reg(3), 32'h07C0);

        read_check("rd_reg0", 5'h00, 32'h0000_0140);
        tick();
        check("rdv_single", {31'b0, avs_s1_readdatavalid}, 32'd0);

        // Byte-lane writes
        avs_write(5'h03, 32'h1234_ABCD, 4'b0001);
        read_check("be_lane0", 5'h03, 32'h0000_07CD);
        check("be_act3", exp_reg(3), 32'h07C0);
        avs_write(5'h05, 32'h1234_ABCD, 4'b1111);
        read_check("be_full", 5'h05, 32'h0000_ABCD);
        avs_write(5'h05, 32'h0000_5500, 4'b0010);
        read_check("be_lane1", 5'h05, 32'h0000_55CD);

        // Unmapped address and read-over-write priority
        avs_write(5'h0F, 32'hFFFF_FFFF, 4'b1111);
        read_check("unmapped", 5'h0F, 32'd0);
        avs_s1_address    = 5'h02;
        avs_s1_writedata  = 32'h0000_BEEF;
        avs_s1_byteenable = 4'b1111;
        avs_s1_write      = 1'b1;
        avs_s1_read       = 1'b1;
        tick();
        avs_s1_write = 1'b0;
        avs_s1_read  = 1'b0;
        check("rw_rdata", avs_s1_readdata, 32'd0);
        read_check("rw_dropped", 5'h02, 32'd0);

        // Frame-synchronised commit
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        avs_write(5'h08, 32'h0000_0500, 4'b0011);
        avs_write(5'h1E, 32'h1, 4'b0001);
        read_check("pend_status", 5'h1D, 32'h0000_0001);
        tick();
        tick();
        check("pend_act8", exp_reg(8), 32'h0000);
        avs_s1_address        = 5'h00;
        avs_export_update_ack = 1'b1;
        tick();
        avs_export_update_ack = 1'b0;
        read_check("pend_ackign", 5'h1D, 32'h0000_0001);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("fs_act8", exp_reg(8), 32'h0500);
        check("fs_req", {31'b0, avs_export_update_req}, 32'd1);
        read_check("req_status", 5'h1D, 32'h0000_0102);
        tick();
        check("req_hold", {31'b0, avs_export_update_req}, 32'd1);
        avs_export_update_ack = 1'b1;
        tick();
        avs_export_update_ack = 1'b0;
        check("ack_req", {31'b0, avs_export_update_req}, 32'd0);
        read_check("ack_status", 5'h1D, 32'h0000_0100);

        // Immediate commit, overrun, overrun clear
        avs_write(5'h01, 32'h0000_1111, 4'b0011);
        avs_write(5'h1E, 32'h3, 4'b0001);
        check("imm_act1", exp_reg(1), 32'h1111);
        check("imm_req", {31'b0, avs_export_update_req}, 32'd1);
        avs_write(5'h1E, 32'h1, 4'b0001);
        read_check("ovr_status", 5'h1D, 32'h0000_0206);
        avs_write(5'h1D, 32'h4, 4'b0001);
        read_check("ovr_clear", 5'h1D, 32'h0000_0202);
        avs_export_update_ack = 1'b1;
        tick();
        avs_export_update_ack = 1'b0;

        // Shadow write coincident with copy: active takes the old value
        avs_write(5'h1E, 32'h1, 4'b0001);
        avs_s1_address    = 5'h04;
        avs_s1_writedata  = 32'h0000_4444;
        avs_s1_byteenable = 4'b0011;
        avs_s1_write      = 1'b1;
        frame_start       = 1'b1;
        tick();
        avs_s1_write = 1'b0;
        frame_start  = 1'b0;
        check("same_act4", exp_reg(4), 32'h0000);
        read_check("same_shadow4", 5'h04, 32'h0000_4444);
        check("same_req", {31'b0, avs_export_update_req}, 32'd1);

        // Reset in REQ, with a read issued in the reset cycle
        reset          = 1'b1;
        avs_s1_address = 5'h00;
        avs_s1_read    = 1'b1;
        tick();
        reset       = 1'b0;
        avs_s1_read = 1'b0;
        check("mrst_rdv",  {31'b0, avs_s1_readdatavalid}, 32'd0);
        check("mrst_req",  {31'b0, avs_export_update_req}, 32'd0);
        check("mrst_act1", exp_reg(1), 32'h0000);
        check("mrst_act8", exp_reg(8), 32'h0000);
        check("mrst_act0", exp_reg(0), 32'h0140);
        read_check("mrst_status", 5'h1D, 32'd0);
        read_check("mrst_sh3", 5'h03, 32'h0000_07C0);

        // Commit counter wrap
        for (int n = 0; n < 255; n++) begin
            avs_write(5'h1E, 32'h3, 4'b0001);
            avs_export_update_ack = 1'b1;
            tick();
            avs_export_update_ack = 1'b0;
        end
        read_check("cnt_255", 5'h1D, 32'h0000_FF00);
        avs_write(5'h1E, 32'h3, 4'b0001);
        avs_export_update_ack = 1'b1;
        tick();
        avs_export_update_ack = 1'b0;
        read_check("cnt_wrap", 5'h1D, 32'h0000_0000);

        // Soft reset register
        avs_write(5'h1F, 32'h0, 4'b0001);
        check("soft_out0", {31'b0, avs_export_cam_soft_reset_n}, 32'd0);
        read_check("soft_rd0", 5'h1F, 32'd0);
        avs_write(5'h1F, 32'h1, 4'b0000);
        check("soft_nobe", {31'b0, avs_export_cam_soft_reset_n}, 32'd0);
        avs_write(5'h1F, 32'hFFFF_FFFF, 4'b0001);
        read_check("soft_rd1", 5'h1F, 32'd1);
        read_check("ctrl_rd", 5'h1E, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
